ghost_catch_monitor: RTL
========================

// Module: ghost_catch_monitor
// PURPOSE
//   Consumer of the ghost mover's position outputs (x, y). Compares the ghost and Pacman
//   sprite boxes on every movement tick and confirms a catch. Runs the life/respawn state
//   machine. Drives freeze (stall both movers), respawn (movers reload start positions),
//   lives and game_over to the game top level and the score/VGA overlay.
// PARAMETERS
//   SPRITE_W      16  overlap half-window in x, pixels; boxes overlap when |dx| < SPRITE_W
//   SPRITE_H      16  overlap half-window in y, pixels; boxes overlap when |dy| < SPRITE_H
//   LIVES         3   lives loaded at reset/restart; range 1..3
//   HIT_CONFIRM   2   consecutive overlapping ticks required to declare a catch; >= 1
//   FREEZE_TICKS  64  ticks spent frozen after a catch; range 1..255
// PORTS
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active-high
//   tick       in   1   movement-step strobe, one clk wide (same rate as mover updates)
//   pac_x      in   10  Pacman x position
//   pac_y      in   9   Pacman y position
//   ghost_x    in   10  ghost x position
//   ghost_y    in   9   ghost y position
//   start      in   1   restart request; acted on only in OVER
//   freeze     out  1   high = movers must hold position
//   respawn    out  1   one-clk pulse: movers reload initial position/direction
//   hit        out  1   one-clk pulse on a confirmed catch
//   lives      out  2   remaining lives
//   game_over  out  1   high while in OVER
//   state      out  2   FSM state, for debug/overlay
// BEHAVIOUR
//   - One clock, one domain. rst is asynchronous and active-high. All outputs are registered.
//   - Reset values: state=PLAY, lives=LIVES, freeze=0, respawn=0, hit=0, game_over=0.
//     Internal confirm counter and freeze timer reset to 0.
//   - Overlap (combinational): dx = |pac_x - ghost_x| using an 11-bit signed difference;
//     dy = |pac_y - ghost_y| using a 10-bit signed difference.
//     overlap = (dx < SPRITE_W) && (dy < SPRITE_H). No wrap-around: 0 vs 1023 is far apart.
//   - Inputs are sampled only in cycles where tick=1. Cycles without tick change nothing
//     except clearing the one-clk pulse outputs.
//   - States: PLAY=0, CAUGHT=1, RESPAWN=2, OVER=3.
//   - PLAY, on tick:
//       overlap=0 -> confirm counter cleared.
//       overlap=1 -> counter increments.
//       Counter reaches HIT_CONFIRM -> next cycle: hit=1, lives decremented,
//       freeze=1, timer=FREEZE_TICKS, state=CAUGHT, counter cleared.
//   - CAUGHT: freeze=1. Timer decrements on each tick. When a tick arrives with timer==1:
//       lives==0 -> state=OVER, game_over=1.
//       otherwise -> state=RESPAWN.
//   - RESPAWN: lasts exactly one clk. respawn=1, freeze stays 1. Next state=PLAY with
//     freeze=0. A tick arriving in this cycle is ignored.
//   - OVER: freeze=1, game_over=1, tick ignored. start=1 -> lives=LIVES, state=RESPAWN,
//     game_over cleared in the same edge. start=1 in any other state is ignored.
//   - lives never underflows; it decrements only in PLAY, and a catch at lives==1 leads to OVER.
//   - Latency: confirming tick at cycle t -> hit/freeze visible at t+1.
//     CAUGHT -> RESPAWN -> PLAY spans FREEZE_TICKS ticks + 1 clk.
//   - rst asserted mid-CAUGHT or mid-OVER returns to PLAY immediately with full lives.
// STRUCTURE
//   - pacman_pkg: game_state_t enum (PLAY/CAUGHT/RESPAWN/OVER), X_W=10, Y_W=9 width
//     constants. Shared with the mover and the overlay.
//   - Sub-module sprite_overlap (params W, H): purely combinational box compare; reused
//     later for pellet pickup.
//   - FSM, confirm counter, freeze timer and lives register live in this module.
// TESTING
//   1. Reset, ghost at (200,146), pac at (20,20), 10 ticks -> no hit, freeze=0, lives=3.
//   2. Pac at (205,150), 2 ticks -> hit pulse 1 clk after the 2nd tick;
//      lives=2, freeze=1, state=CAUGHT.
//   3. Overlap on tick 1, separated on tick 2, overlap on tick 3 -> no hit
//      (counter clears); tick 4 overlap -> hit.
//   4. After a catch, 64 ticks -> RESPAWN for 1 clk (respawn=1),
//      then PLAY with freeze=0; ticks during RESPAWN have no effect.
//   5. Three catches -> OVER, game_over=1, lives=0. start=1 -> respawn pulse,
//      lives=3, PLAY.
//   6. Edge cases: dx=15 overlaps, dx=16 does not; pac_x=0 vs ghost_x=1023 -> no overlap;
//      rst mid-CAUGHT -> PLAY, lives=3, freeze=0.

Source files
------------

// File: rtl/pacman_pkg.sv
// ============================================================================
// pacman_pkg : shared game-state encoding and position widths
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package pacman_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    GS_PLAY    = 2'd0,
    GS_CAUGHT  = 2'd1,
    GS_RESPAWN = 2'd2,
    GS_OVER    = 2'd3
  } game_state_t;

  localparam logic [1:0] ST_PLAY    = GS_PLAY;
  localparam logic [1:0] ST_CAUGHT  = GS_CAUGHT;
  localparam logic [1:0] ST_RESPAWN = GS_RESPAWN;
  localparam logic [1:0] ST_OVER    = GS_OVER;
endpackage

`default_nettype wire

// File: rtl/sprite_overlap.sv
// ============================================================================
// sprite_overlap : combinational box compare, |dx| < W and |dy| < H
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module sprite_overlap
  import pacman_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic [X_W-1:0] ax,
  input  logic [Y_W-1:0] ay,
  input  logic [X_W-1:0] bx,
  input  logic [Y_W-1:0] by,
  output logic           overlap
);
  localparam logic [X_W:0] W_LIM = W[X_W:0];
  localparam logic [Y_W:0] H_LIM = H[Y_W:0];

  logic signed [X_W:0] dx_s;
  logic signed [Y_W:0] dy_s;
  logic        [X_W:0] dx_abs;
  logic        [Y_W:0] dy_abs;

  // One extra bit keeps the difference exact, so the edges never wrap.
  assign dx_s   = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign dy_s   = $signed({1'b0, ay}) - $signed({1'b0, by});
  assign dx_abs = dx_s[X_W] ? $unsigned(-dx_s) : $unsigned(dx_s);
  assign dy_abs = dy_s[Y_W] ? $unsigned(-dy_s) : $unsigned(dy_s);

  assign overlap = (dx_abs < W_LIM) && (dy_abs < H_LIM);
endmodule

`default_nettype wire

// File: rtl/ghost_catch_monitor.sv
// ============================================================================
// ghost_catch_monitor : catch confirmation plus life/respawn state machine
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module ghost_catch_monitor
  import pacman_pkg::*;
#(
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int LIVES        = 3,
  parameter int HIT_CONFIRM  = 2,
  parameter int FREEZE_TICKS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [X_W-1:0] pac_x,
  input  logic [Y_W-1:0] pac_y,
  input  logic [X_W-1:0] ghost_x,
  input  logic [Y_W-1:0] ghost_y,
  input  logic           start,
  output logic           freeze,
  output logic           respawn,
  output logic           hit,
  output logic [1:0]     lives,
  output logic           game_over,
  output logic [1:0]     state
);
  localparam int               CNT_W        = $clog2(HIT_CONFIRM + 1);
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(HIT_CONFIRM - 1);
  localparam logic [1:0]       LIVES_INIT   = 2'(LIVES);
  localparam logic [7:0]       TIMER_INIT   = 8'(FREEZE_TICKS);

  logic             overlap;
  logic [CNT_W-1:0] confirm_cnt;
  logic [7:0]       freeze_timer;

  sprite_overlap #(
    .W (SPRITE_W),
    .H (SPRITE_H)
  ) u_overlap (
    .ax      (pac_x),
    .ay      (pac_y),
    .bx      (ghost_x),
    .by      (ghost_y),
    .overlap (overlap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_PLAY;
      lives        <= LIVES_INIT;
      freeze       <= 1'b0;
      respawn      <= 1'b0;
      hit          <= 1'b0;
      game_over    <= 1'b0;
      confirm_cnt  <= '0;
      freeze_timer <= '0;
    end else begin
      hit     <= 1'b0;
      respawn <= 1'b0;
      case (state)
        ST_PLAY: begin
          if (tick) begin
            if (!overlap) begin
              confirm_cnt <= '0;
            end else if (confirm_cnt == CONFIRM_LAST) begin
              hit          <= 1'b1;
              freeze       <= 1'b1;
              freeze_timer <= TIMER_INIT;
              state        <= ST_CAUGHT;
              confirm_cnt  <= '0;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end else begin
              confirm_cnt <= confirm_cnt + 1'b1;
            end
          end
        end
        ST_CAUGHT: begin
          if (tick) begin
            if (freeze_timer == 8'd1) begin
              freeze_timer <= '0;
              // Lives already reflect this catch, so zero here means the last life is gone.
              if (lives == 2'd0) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
              end else begin
                state   <= ST_RESPAWN;
                respawn <= 1'b1;
              end
            end else begin
              freeze_timer <= freeze_timer - 8'd1;
            end
          end
        end
        ST_RESPAWN: begin
          state  <= ST_PLAY;
          freeze <= 1'b0;
        end
        ST_OVER: begin
          if (start) begin
            lives     <= LIVES_INIT;
            state     <= ST_RESPAWN;
            game_over <= 1'b0;
            respawn   <= 1'b1;
          end
        end
        default: state <= ST_PLAY;
      endcase
    end
  end
endmodule

`default_nettype wire
